// File: rtl/fft_seq_ctrl_if.sv
// Handshake and memory-address bundle between the FFT sequencer, the host and the
// butterfly datapath / dual-port data RAM.
interface fft_seq_ctrl_if #(parameter int LOG2N = 3);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [3:0]           stage;
    logic [LOG2N-2:0]     bf_idx;
    logic                 rd_en;
    logic [LOG2N-1:0]     rd_addr_a;
    logic [LOG2N-1:0]     rd_addr_b;
    logic [LOG2N-2:0]     tw_addr;
    logic                 wr_en;
    logic [LOG2N-1:0]     wr_addr_a;
    logic [LOG2N-1:0]     wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage, bf_idx, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage, bf_idx, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks stages/butterflies, issues read and twiddle
// addresses, and replays them as write-back addresses PIPE_LAT cycles later.
module fft_seq_ctrl #(
    parameter int LOG2N    = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic           clk,
    input  logic           sclr_n,
    fft_seq_ctrl_if.master bus
);
    localparam int KW = LOG2N - 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [3:0]    s, s_nxt;
    logic [KW-1:0] k, k_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic          run_nxt;

    logic [LOG2N-1:0] kx, span, mask, addr_a, addr_b, tw_full;
    logic [4:0]       s1;
    logic [3:0]       tsh;
    logic [LOG2N-1:0] a_nxt, b_nxt;
    logic [KW-1:0]    tw_nxt, bf_nxt;
    logic [3:0]       st_nxt;

    // Index 0 is the read-side register; index PIPE_LAT is the write-back tap.
    logic [PIPE_LAT:0]            vld_pipe;
    logic [PIPE_LAT:0][LOG2N-1:0] a_pipe, b_pipe;
    logic [KW-1:0]                tw_q, bf_q;
    logic [3:0]                   st_q;

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        k_nxt     = k;
        dcnt_nxt  = dcnt;
        case (state)
            IDLE: if (bus.start) begin
                state_nxt = RUN;
                s_nxt     = '0;
                k_nxt     = '0;
            end
            RUN: if (k == '1) begin
                state_nxt = DRAIN;
                k_nxt     = '0;
                dcnt_nxt  = '0;
            end else begin
                k_nxt = k + KW'(1);
            end
            DRAIN: if (dcnt == DW'(PIPE_LAT - 1)) begin
                if (s == 4'(LOG2N - 1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                    s_nxt     = s + 4'd1;
                end
            end else begin
                dcnt_nxt = dcnt + DW'(1);
            end
            DONE: begin
                state_nxt = IDLE;
                s_nxt     = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are computed from the next butterfly so the outputs come straight from flops.
    always_comb begin
        run_nxt = (state_nxt == RUN);
        kx      = {1'b0, k_nxt};
        span    = LOG2N'(1) << s_nxt;
        mask    = span - LOG2N'(1);
        s1      = {1'b0, s_nxt} + 5'd1;
        tsh     = 4'(LOG2N - 1) - s_nxt;
        addr_a  = ((kx >> s_nxt) << s1) | (kx & mask);
        addr_b  = addr_a + span;
        tw_full = (kx & mask) << tsh;
        a_nxt   = run_nxt ? addr_a : '0;
        b_nxt   = run_nxt ? addr_b : '0;
        tw_nxt  = run_nxt ? tw_full[KW-1:0] : '0;
        bf_nxt  = run_nxt ? k_nxt : '0;
        st_nxt  = run_nxt ? s_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state    <= IDLE;
            s        <= '0;
            k        <= '0;
            dcnt     <= '0;
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
            tw_q     <= '0;
            bf_q     <= '0;
            st_q     <= '0;
        end else begin
            state    <= state_nxt;
            s        <= s_nxt;
            k        <= k_nxt;
            dcnt     <= dcnt_nxt;
            vld_pipe <= {vld_pipe[PIPE_LAT-1:0], run_nxt};
            a_pipe   <= {a_pipe[PIPE_LAT-1:0], a_nxt};
            b_pipe   <= {b_pipe[PIPE_LAT-1:0], b_nxt};
            tw_q     <= tw_nxt;
            bf_q     <= bf_nxt;
            st_q     <= st_nxt;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.rd_en     = vld_pipe[0];
    assign bus.rd_addr_a = a_pipe[0];
    assign bus.rd_addr_b = b_pipe[0];
    assign bus.tw_addr   = tw_q;
    assign bus.stage     = st_q;
    assign bus.bf_idx    = bf_q;
    assign bus.wr_en     = vld_pipe[PIPE_LAT];
    assign bus.wr_addr_a = a_pipe[PIPE_LAT];
    assign bus.wr_addr_b = b_pipe[PIPE_LAT];
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: default N=8/PIPE_LAT=2 instance plus N=16/PIPE_LAT=1.
module tb_fft_seq_ctrl;
    typedef struct {int cyc; int a; int b; int tw; int st; int k;} exp_t;
    typedef struct {int lo; int hi;} win_t;

    localparam int BIG = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic sclr0, sclr1;
    int   pe = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;

    exp_t rdq[2][$];
    exp_t wrq[2][$];
    int   dnq[2][$];
    win_t bwq[2][$];

    // Hand-derived N=8 butterfly table, stage-major.
    int tab_a[12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tab_b[12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tab_t[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    fft_seq_ctrl_if #(.LOG2N(3)) bus0 ();
    fft_seq_ctrl_if #(.LOG2N(4)) bus1 ();

    fft_seq_ctrl #(.LOG2N(3), .PIPE_LAT(2)) dut0 (.clk(clk), .sclr_n(sclr0), .bus(bus0.master));
    fft_seq_ctrl #(.LOG2N(4), .PIPE_LAT(1)) dut1 (.clk(clk), .sclr_n(sclr1), .bus(bus1.master));

    always #5 clk = ~clk;
    always @(posedge clk) pe++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected cycle c of a run launched with start driven while pe==base is pe==base+c.
    task automatic push_run(input int d, input int base, input int cut);
        int L, PL, n2, sc, span, k, c;
        exp_t e;
        win_t w;
        L  = (d == 0) ? 3 : 4;
        PL = (d == 0) ? 2 : 1;
        n2 = 1 << (L - 1);
        sc = n2 + PL;
        for (int s = 0; s < L; s++) begin
            span = 1 << s;
            for (int g = 0; g < n2 / span; g++) begin
                for (int j = 0; j < span; j++) begin
                    k = g * span + j;
                    c = base + 1 + s * sc + k;
                    e.cyc = c; e.st = s; e.k = k;
                    if (d == 0) begin
                        e.a = tab_a[s*4+k]; e.b = tab_b[s*4+k]; e.tw = tab_t[s*4+k];
                    end else begin
                        e.a = g * 2 * span + j; e.b = e.a + span; e.tw = j * (n2 / span);
                    end
                    if (c <= cut) rdq[d].push_back(e);
                    if (c + PL <= cut) begin
                        e.cyc = c + PL;
                        wrq[d].push_back(e);
                    end
                end
            end
        end
        c = base + L * sc + 1;
        if (c <= cut) dnq[d].push_back(c);
        w.lo = base + 1;
        w.hi = (c < cut) ? c : cut;
        bwq[d].push_back(w);
    endtask

    always @(negedge clk) begin
        logic [31:0] en[2], a[2], b[2], t[2], st[2], k[2], we[2], wa[2], wb[2], bz[2], dn[2];
        exp_t e;
        bit   xb;
        en[0] = 32'(bus0.rd_en);     en[1] = 32'(bus1.rd_en);
        a[0]  = 32'(bus0.rd_addr_a); a[1]  = 32'(bus1.rd_addr_a);
        b[0]  = 32'(bus0.rd_addr_b); b[1]  = 32'(bus1.rd_addr_b);
        t[0]  = 32'(bus0.tw_addr);   t[1]  = 32'(bus1.tw_addr);
        st[0] = 32'(bus0.stage);     st[1] = 32'(bus1.stage);
        k[0]  = 32'(bus0.bf_idx);    k[1]  = 32'(bus1.bf_idx);
        we[0] = 32'(bus0.wr_en);     we[1] = 32'(bus1.wr_en);
        wa[0] = 32'(bus0.wr_addr_a); wa[1] = 32'(bus1.wr_addr_a);
        wb[0] = 32'(bus0.wr_addr_b); wb[1] = 32'(bus1.wr_addr_b);
        bz[0] = 32'(bus0.busy);      bz[1] = 32'(bus1.busy);
        dn[0] = 32'(bus0.done);      dn[1] = 32'(bus1.done);
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                // read side
                if (rdq[d].size() > 0 && rdq[d][0].cyc < pe) begin
                    n_chk++; n_fail++;
                    $display("FAIL rd_missing dut%0d pe=%0d: no rd_en, required read at pe=%0d", d, pe, rdq[d][0].cyc);
                    void'(rdq[d].pop_front());
                end
                n_chk++;
                if (en[d] === 32'd1) begin
                    if (rdq[d].size() == 0 || rdq[d][0].cyc != pe) begin
                        n_fail++;
                        $display("FAIL rd_unexpected dut%0d pe=%0d: rd_en=1 a=%0d b=%0d, required rd_en=0", d, pe, a[d], b[d]);
                    end else begin
                        e = rdq[d].pop_front();
                        if (a[d] !== 32'(e.a) || b[d] !== 32'(e.b) || t[d] !== 32'(e.tw) ||
                            st[d] !== 32'(e.st) || k[d] !== 32'(e.k)) begin
                            n_fail++;
                            $display("FAIL rd dut%0d pe=%0d: got a=%0d b=%0d tw=%0d s=%0d k=%0d, required a=%0d b=%0d tw=%0d s=%0d k=%0d",
                                     d, pe, a[d], b[d], t[d], st[d], k[d], e.a, e.b, e.tw, e.st, e.k);
                        end
                    end
                end else if (en[d] !== 32'd0 || a[d] !== 0 || b[d] !== 0 || t[d] !== 0 ||
                             st[d] !== 0 || k[d] !== 0) begin
                    n_fail++;
                    $display("FAIL rd_idle dut%0d pe=%0d: got en=%0h a=%0h b=%0h tw=%0h s=%0h k=%0h, required all 0",
                             d, pe, en[d], a[d], b[d], t[d], st[d], k[d]);
                end
                // write side
                if (wrq[d].size() > 0 && wrq[d][0].cyc < pe) begin
                    n_chk++; n_fail++;
                    $display("FAIL wr_missing dut%0d pe=%0d: no wr_en, required write at pe=%0d", d, pe, wrq[d][0].cyc);
                    void'(wrq[d].pop_front());
                end
                n_chk++;
                if (we[d] === 32'd1) begin
                    if (wrq[d].size() == 0 || wrq[d][0].cyc != pe) begin
                        n_fail++;
                        $display("FAIL wr_unexpected dut%0d pe=%0d: wr_en=1 a=%0d b=%0d, required wr_en=0", d, pe, wa[d], wb[d]);
                    end else begin
                        e = wrq[d].pop_front();
                        if (wa[d] !== 32'(e.a) || wb[d] !== 32'(e.b)) begin
                            n_fail++;
                            $display("FAIL wr dut%0d pe=%0d: got a=%0d b=%0d, required a=%0d b=%0d", d, pe, wa[d], wb[d], e.a, e.b);
                        end
                    end
                end else if (we[d] !== 32'd0 || wa[d] !== 0 || wb[d] !== 0) begin
                    n_fail++;
                    $display("FAIL wr_idle dut%0d pe=%0d: got en=%0h a=%0h b=%0h, required all 0", d, pe, we[d], wa[d], wb[d]);
                end
                // done pulse
                while (dnq[d].size() > 0 && dnq[d][0] < pe) void'(dnq[d].pop_front());
                xb = (dnq[d].size() > 0 && dnq[d][0] == pe);
                n_chk++;
                if (dn[d] !== 32'(xb)) begin
                    n_fail++;
                    $display("FAIL done dut%0d pe=%0d: got %0h, required %0d", d, pe, dn[d], xb);
                end
                // busy window
                while (bwq[d].size() > 0 && bwq[d][0].hi < pe) void'(bwq[d].pop_front());
                xb = (bwq[d].size() > 0 && bwq[d][0].lo <= pe && pe <= bwq[d][0].hi);
                n_chk++;
                if (bz[d] !== 32'(xb)) begin
                    n_fail++;
                    $display("FAIL busy dut%0d pe=%0d: got %0h, required %0d", d, pe, bz[d], xb);
                end
            end
        end
    end

    initial begin
        int base;
        // reset held 3 edges with start asserted
        sclr0 = 1'b0; sclr1 = 1'b0;
        bus0.start = 1'b1; bus1.start = 1'b1;
        @(posedge clk); #1 mon_on = 1'b1;
        tick(2);
        bus0.start = 1'b0; bus1.start = 1'b0;
        sclr0 = 1'b1; sclr1 = 1'b1;
        tick(2);

        // single run on both instances
        base = pe;
        bus0.start = 1'b1; bus1.start = 1'b1;
        push_run(0, base, BIG);
        push_run(1, base, BIG);
        tick(1);
        bus0.start = 1'b0; bus1.start = 1'b0;
        tick(45);

        // start held for 30 cycles: relaunch only from the IDLE cycle after DONE
        base = pe;
        bus0.start = 1'b1;
        push_run(0, base, BIG);
        push_run(0, base + 20, BIG);
        tick(30);
        bus0.start = 1'b0;
        tick(15);

        // reset in stage-1 cycle 8, then a fresh run
        base = pe;
        bus0.start = 1'b1;
        push_run(0, base, base + 8);
        tick(1);
        bus0.start = 1'b0;
        tick(7);
        sclr0 = 1'b0;
        tick(3);
        sclr0 = 1'b1;
        tick(2);
        base = pe;
        bus0.start = 1'b1;
        push_run(0, base, BIG);
        tick(1);
        bus0.start = 1'b0;
        tick(25);

        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (rdq[d].size() != 0 || wrq[d].size() != 0 || dnq[d].size() != 0) begin
                n_fail++;
                $display("FAIL leftover dut%0d: got rd=%0d wr=%0d done=%0d pending, required 0",
                         d, rdq[d].size(), wrq[d].size(), dnq[d].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
